// File: rtl/ncl_dr_pkg.sv
// Shared dual-rail encoding, helpers and handshake state for the clocked NCL counter.
package ncl_dr_pkg;

  typedef logic [1:0] dr_t;

  localparam dr_t DR_NULL = 2'b00;
  localparam dr_t DR_0    = 2'b01;
  localparam dr_t DR_1    = 2'b10;
  localparam dr_t DR_ILL  = 2'b11;

  typedef enum logic {NULL_OUT, DATA_OUT} state_t;

  function automatic logic dr_is_data(input dr_t d);
    return (d == DR_0) || (d == DR_1);
  endfunction

  function automatic logic dr_val(input dr_t d);
    return d == DR_1;
  endfunction

endpackage

// File: rtl/ncl_dr_outreg.sv
// Registered binary-to-dual-rail output bank; a whole wavefront loads or clears on one edge.
module ncl_dr_outreg
  import ncl_dr_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               load_data_i,
  input  logic               load_null_i,
  input  logic [WIDTH-1:0]   bin_i,
  output logic [2*WIDTH-1:0] dr_o
);

  logic [2*WIDTH-1:0] dr_q;
  logic [2*WIDTH-1:0] dr_d;
  logic [2*WIDTH-1:0] enc;

  always_comb begin
    enc = '0;
    for (int i = 0; i < WIDTH; i++) begin
      enc[2*i +: 2] = bin_i[i] ? DR_1 : DR_0;
    end
  end

  always_comb begin
    dr_d = dr_q;
    if (load_null_i)      dr_d = '0;
    else if (load_data_i) dr_d = enc;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) dr_q <= '0;
    else       dr_q <= dr_d;
  end

  assign dr_o = dr_q;

endmodule

// File: rtl/ncl_dr_counter_sync.sv
// Clocked dual-rail up/down counter stage with four-phase return-to-NULL handshake
// and joint sum+carry completion.
module ncl_dr_counter_sync
  import ncl_dr_pkg::*;
#(
  parameter int          WIDTH      = 32,
  parameter int unsigned INIT_VALUE = 0,
  parameter bit          CARRY_EN   = 1'b1
) (
  input  logic               clk,
  input  logic               init,
  input  logic [1:0]         carryin,
  output logic               carryinCOMP,
  input  logic               down,
  output logic [2*WIDTH-1:0] sum,
  input  logic               sumCOMP,
  output logic [1:0]         carryout,
  input  logic               carryoutCOMP,
  output logic [WIDTH-1:0]   count,
  output logic               err
);

  localparam logic [WIDTH-1:0] INIT_CNT = WIDTH'(INIT_VALUE);

  state_t           state_q;
  logic             comp_q;
  logic             err_q;
  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;
  logic             ack;
  logic             inc;
  logic             cy;
  logic             acc_data;
  logic             rtn_null;

  assign ack = sumCOMP & (CARRY_EN ? carryoutCOMP : 1'b1);
  assign inc = dr_val(carryin);

  always_comb begin
    if (down) begin
      count_d = count_q - WIDTH'(inc);
      cy      = inc & (count_q == '0);
    end else begin
      count_d = count_q + WIDTH'(inc);
      cy      = inc & (&count_q);
    end
  end

  // Handshake qualifiers: data waits for the consumer's NULL ack, NULL for its DATA ack.
  assign acc_data = (state_q == NULL_OUT) && dr_is_data(carryin) && !ack;
  assign rtn_null = (state_q == DATA_OUT) && (carryin == DR_NULL) && ack;

  always_ff @(posedge clk) begin
    if (init) begin
      state_q <= NULL_OUT;
      comp_q  <= 1'b0;
      count_q <= INIT_CNT;
      err_q   <= 1'b0;
    end else begin
      if (carryin == DR_ILL) err_q <= 1'b1;
      case (state_q)
        NULL_OUT: if (acc_data) begin
          count_q <= count_d;
          comp_q  <= 1'b1;
          state_q <= DATA_OUT;
        end
        DATA_OUT: if (rtn_null) begin
          comp_q  <= 1'b0;
          state_q <= NULL_OUT;
        end
        default: state_q <= NULL_OUT;
      endcase
    end
  end

  ncl_dr_outreg #(.WIDTH(WIDTH)) u_sum (
    .clk_i       (clk),
    .rst_i       (init),
    .load_data_i (acc_data),
    .load_null_i (rtn_null),
    .bin_i       (count_d),
    .dr_o        (sum)
  );

  // With carry disabled the carry bank never loads and stays NULL.
  ncl_dr_outreg #(.WIDTH(1)) u_carry (
    .clk_i       (clk),
    .rst_i       (init),
    .load_data_i (acc_data && CARRY_EN),
    .load_null_i (rtn_null),
    .bin_i       (cy),
    .dr_o        (carryout)
  );

  assign carryinCOMP = comp_q;
  assign count       = count_q;
  assign err         = err_q;

endmodule

// File: tb/tb_ncl_dr_counter_sync.sv
// Directed bench for ncl_dr_counter_sync across default, 4-bit and carry-disabled builds.
module tb_ncl_dr_counter_sync;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Instance A: defaults (WIDTH=32, INIT_VALUE=0, CARRY_EN=1)
  logic        init_a, down_a, sc_a, cc_a, comp_a, err_a;
  logic [1:0]  ci_a, co_a;
  logic [63:0] sum_a;
  logic [31:0] cnt_a;

  // Instances B/C/D share init
  logic        init_o;
  logic        down_b, sc_b, cc_b, comp_b, err_b;
  logic [1:0]  ci_b, co_b;
  logic [7:0]  sum_b;
  logic [3:0]  cnt_b;
  logic        down_c, sc_c, cc_c, comp_c, err_c;
  logic [1:0]  ci_c, co_c;
  logic [7:0]  sum_c;
  logic [3:0]  cnt_c;
  logic        down_d, sc_d, cc_d, comp_d, err_d;
  logic [1:0]  ci_d, co_d;
  logic [7:0]  sum_d;
  logic [3:0]  cnt_d;

  ncl_dr_counter_sync u_a (
    .clk(clk), .init(init_a), .carryin(ci_a), .carryinCOMP(comp_a), .down(down_a),
    .sum(sum_a), .sumCOMP(sc_a), .carryout(co_a), .carryoutCOMP(cc_a),
    .count(cnt_a), .err(err_a)
  );

  ncl_dr_counter_sync #(.WIDTH(4), .INIT_VALUE(15), .CARRY_EN(1'b1)) u_b (
    .clk(clk), .init(init_o), .carryin(ci_b), .carryinCOMP(comp_b), .down(down_b),
    .sum(sum_b), .sumCOMP(sc_b), .carryout(co_b), .carryoutCOMP(cc_b),
    .count(cnt_b), .err(err_b)
  );

  ncl_dr_counter_sync #(.WIDTH(4), .INIT_VALUE(0), .CARRY_EN(1'b1)) u_c (
    .clk(clk), .init(init_o), .carryin(ci_c), .carryinCOMP(comp_c), .down(down_c),
    .sum(sum_c), .sumCOMP(sc_c), .carryout(co_c), .carryoutCOMP(cc_c),
    .count(cnt_c), .err(err_c)
  );

  ncl_dr_counter_sync #(.WIDTH(4), .INIT_VALUE(0), .CARRY_EN(1'b0)) u_d (
    .clk(clk), .init(init_o), .carryin(ci_d), .carryinCOMP(comp_d), .down(down_d),
    .sum(sum_d), .sumCOMP(sc_d), .carryout(co_d), .carryoutCOMP(cc_d),
    .count(cnt_d), .err(err_d)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    init_a = 1'b1; ci_a = 2'b00; down_a = 1'b0; sc_a = 1'b0; cc_a = 1'b0;
    init_o = 1'b1;
    ci_b = 2'b00; down_b = 1'b0; sc_b = 1'b0; cc_b = 1'b0;
    ci_c = 2'b00; down_c = 1'b0; sc_c = 1'b0; cc_c = 1'b0;
    ci_d = 2'b00; down_d = 1'b0; sc_d = 1'b0; cc_d = 1'b0;
    step(); step();
    init_a = 1'b0; init_o = 1'b0;

    chk("rst_sum_a",  64'(sum_a), 64'h0);
    chk("rst_co_a",   64'(co_a), 64'h0);
    chk("rst_comp_a", 64'(comp_a), 64'h0);
    chk("rst_cnt_a",  64'(cnt_a), 64'h0);
    chk("rst_err_a",  64'(err_a), 64'h0);
    chk("rst_cnt_b",  64'(cnt_b), 64'hF);

    // Increment by one from 0
    ci_a = 2'b10; step();
    chk("inc_cnt_a",  64'(cnt_a), 64'h1);
    chk("inc_sum_a",  64'(sum_a), 64'h5555_5555_5555_5556);
    chk("inc_co_a",   64'(co_a), 64'h1);
    chk("inc_comp_a", 64'(comp_a), 64'h1);
    ci_a = 2'b00; sc_a = 1'b1; cc_a = 1'b1; step();
    chk("null_sum_a",  64'(sum_a), 64'h0);
    chk("null_co_a",   64'(co_a), 64'h0);
    chk("null_comp_a", 64'(comp_a), 64'h0);
    chk("null_cnt_a",  64'(cnt_a), 64'h1);

    // Delayed consumer ack holds DATA
    sc_a = 1'b0; cc_a = 1'b0; ci_a = 2'b10; step();
    chk("d2_sum_a", 64'(sum_a), 64'h5555_5555_5555_5559);
    ci_a = 2'b00; cc_a = 1'b1;
    for (int i = 0; i < 20; i++) step();
    chk("hold_sum_a",  64'(sum_a), 64'h5555_5555_5555_5559);
    chk("hold_comp_a", 64'(comp_a), 64'h1);
    sc_a = 1'b1; step();
    chk("rel_sum_a", 64'(sum_a), 64'h0);
    ci_a = 2'b10; step(); step();
    chk("wait_sum_a",  64'(sum_a), 64'h0);
    chk("wait_cnt_a",  64'(cnt_a), 64'h2);
    chk("wait_comp_a", 64'(comp_a), 64'h0);
    sc_a = 1'b0; step();
    chk("d3_cnt_a", 64'(cnt_a), 64'h3);
    chk("d3_sum_a", 64'(sum_a), 64'h5555_5555_5555_555A);
    ci_a = 2'b00; sc_a = 1'b1; step();
    chk("d3null_sum_a", 64'(sum_a), 64'h0);

    // Illegal code sets sticky err with no other effect
    ci_a = 2'b11; step();
    chk("ill_err_a",  64'(err_a), 64'h1);
    chk("ill_comp_a", 64'(comp_a), 64'h0);
    chk("ill_cnt_a",  64'(cnt_a), 64'h3);
    chk("ill_sum_a",  64'(sum_a), 64'h0);
    ci_a = 2'b00; step();
    chk("stick_err_a", 64'(err_a), 64'h1);

    // init in DATA_OUT
    sc_a = 1'b0; cc_a = 1'b0; ci_a = 2'b01; step();
    chk("d0_sum_a",  64'(sum_a), 64'h5555_5555_5555_555A);
    chk("d0_co_a",   64'(co_a), 64'h1);
    chk("d0_comp_a", 64'(comp_a), 64'h1);
    init_a = 1'b1; step();
    init_a = 1'b0; ci_a = 2'b00;
    chk("ri_sum_a",  64'(sum_a), 64'h0);
    chk("ri_co_a",   64'(co_a), 64'h0);
    chk("ri_cnt_a",  64'(cnt_a), 64'h0);
    chk("ri_err_a",  64'(err_a), 64'h0);
    chk("ri_comp_a", 64'(comp_a), 64'h0);

    // Up wrap 15 -> 0 with carry
    ci_b = 2'b10; step();
    chk("wrap_sum_b", 64'(sum_b), 64'h55);
    chk("wrap_co_b",  64'(co_b), 64'h2);
    chk("wrap_cnt_b", 64'(cnt_b), 64'h0);

    // Down wrap 0 -> 15 with borrow, then DATA 0
    down_c = 1'b1; ci_c = 2'b10; step();
    chk("dn_cnt_c", 64'(cnt_c), 64'hF);
    chk("dn_sum_c", 64'(sum_c), 64'hAA);
    chk("dn_co_c",  64'(co_c), 64'h2);
    ci_c = 2'b00; sc_c = 1'b1; cc_c = 1'b1; step();
    chk("dn_null_c", 64'(sum_c), 64'h0);
    sc_c = 1'b0; cc_c = 1'b0; ci_c = 2'b01; step();
    chk("dz_cnt_c", 64'(cnt_c), 64'hF);
    chk("dz_sum_c", 64'(sum_c), 64'hAA);
    chk("dz_co_c",  64'(co_c), 64'h1);

    // Carry disabled, carryoutCOMP tied low
    ci_d = 2'b10; step();
    chk("nc1_cnt_d", 64'(cnt_d), 64'h1);
    chk("nc1_sum_d", 64'(sum_d), 64'h56);
    chk("nc1_co_d",  64'(co_d), 64'h0);
    ci_d = 2'b00; sc_d = 1'b1; step();
    chk("nc1_null_d", 64'(sum_d), 64'h0);
    sc_d = 1'b0; ci_d = 2'b10; step();
    chk("nc2_sum_d", 64'(sum_d), 64'h59);
    ci_d = 2'b00; sc_d = 1'b1; step();
    sc_d = 1'b0; ci_d = 2'b10; step();
    chk("nc3_cnt_d", 64'(cnt_d), 64'h3);
    chk("nc3_sum_d", 64'(sum_d), 64'h5A);
    chk("nc3_co_d",  64'(co_d), 64'h0);
    chk("nc3_comp_d", 64'(comp_d), 64'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ncl_dr_counter_sync.md
Name: ncl_dr_counter_sync

Overview:
Clocked, parametrised successor to the four-oscillator dual-rail counter ring. It holds a WIDTH-bit count and takes a dual-rail increment operand over a four-phase return-to-NULL handshake. It emits the updated count as WIDTH dual-rail digits plus a dual-rail carry/borrow, with joint sum+carry completion closure. It also adds up/down mode, a reset preset value and optional carry suppression, and sits as the counter stage between a clocked NCL-style producer and consumer.

Parameters:
WIDTH, 32, number of dual-rail digits (count bits)
INIT_VALUE, 0, count value loaded on init
CARRY_EN, 1, 1 = carryout driven and carryout_comp used in closure; 0 = carryout held NULL and carryout_comp ignored

Ports:
clk  in  1  single clock, rising edge
init  in  1  reset, synchronous, active-high
carryin  in  2  dual-rail increment operand: 00 NULL, 01 DATA 0, 10 DATA 1, 11 illegal
carryinCOMP  out  1  input completion: 1 = DATA accepted, 0 = NULL accepted
down  in  1  direction, sampled only when DATA is accepted: 0 = add, 1 = subtract
sum  out  2*WIDTH  dual-rail count; digit i = sum[2i+1:2i], same encoding as carryin
sumCOMP  in  1  consumer completion for sum: 1 = DATA captured, 0 = NULL captured
carryout  out  2  dual-rail carry (up) or borrow (down)
carryoutCOMP  in  1  consumer completion for carryout
count  out  WIDTH  binary mirror of the stored count
err  out  1  sticky protocol error

Behaviour:
- Reset (init=1 at an edge, overrides everything incl. mid-handshake): sum=all 00, carryout=00, carryinCOMP=0, count=INIT_VALUE[WIDTH-1:0], err=0, state=NULL_OUT.
- Effective completion ack = sumCOMP & (CARRY_EN ? carryoutCOMP : 1).
- NULL_OUT state: outputs NULL, carryinCOMP=0.
  - Accept DATA when carryin is 01 or 10 and ack==0.
  - Next edge: count <= next; sum <= dual-rail(next); carryout <= dual-rail(c); carryinCOMP <= 1; state -> DATA_OUT.
  - With v = carryin==10: up gives next = count+v mod 2^WIDTH, c = v & (count==all-ones). Down gives next = count-v mod 2^WIDTH, c = v & (count==0).
  - DATA 0 still produces a full DATA wavefront with the count unchanged and c=0.
  - CARRY_EN=0: carryout stays 00.
- DATA_OUT state: outputs hold DATA, carryinCOMP=1.
  - Return to NULL when carryin==00 and ack==1.
  - Next edge: sum and carryout <= NULL, carryinCOMP <= 0, state -> NULL_OUT.
- Latency: exactly 1 clk from qualifying condition to output change. sum and carryout always change on the same edge. No output ever shows a mixed DATA/NULL wavefront.
- Waiting: either condition may be held indefinitely. Outputs and count hold until it is met. Input arriving before the ack, or ack before the input, is simply waited on.
- Illegal code: carryin==11 in any state sets err on the next edge. It is not accepted and causes no state or count change. err clears only on init.
- Out of order: carryin DATA while in DATA_OUT, or NULL while in NULL_OUT, is a hold condition, not an error.
- Wrap-around: all-ones+1 -> 0 with c=1; 0-1 -> all-ones with c=1.
- count changes only on the DATA-accept edge.

Decomposition:
- Package ncl_dr_pkg holds:
  - typedef dr_t (2-bit)
  - constants DR_NULL=2'b00, DR_0=2'b01, DR_1=2'b10, DR_ILL=2'b11
  - functions dr_is_data, dr_val
  - state enum {NULL_OUT, DATA_OUT}
- One sub-module, ncl_dr_outreg, parametrised by WIDTH: registered binary-to-dual-rail output bank with load_data / load_null controls. It is instanced once for sum and once (WIDTH=1) for carryout.

Test Plan:
1. Default params, init, then carryin=10, down=0, prompt acks -> 1 clk later count=1, sum digit0=10, digits1..31=01, carryout=01, carryinCOMP=1. carryin=00 with ack=1 -> all outputs 00 next edge.
2. WIDTH=4, INIT_VALUE=15, carryin=10 up -> sum digits = 01,01,01,01 (0), carryout=10, count=0.
3. WIDTH=4, INIT_VALUE=0, down=1, carryin=10 -> count=15, all digits 10, carryout=10. Then carryin=01 -> count stays 15, carryout=01.
4. After DATA, hold sumCOMP=0 for 20 clks with carryin=00 -> sum holds DATA. Raise sumCOMP -> NULL exactly 1 clk later. Next DATA is not accepted until sumCOMP=0.
5. carryin=11 in NULL_OUT -> err=1 next edge, carryinCOMP stays 0, count unchanged. err persists until init.
6. init asserted in DATA_OUT -> next edge all outputs NULL, count=INIT_VALUE, err=0. With CARRY_EN=0 and carryoutCOMP tied 0, 3 increments -> count=3, carryout stays 00.
